// File: rtl/march_bist.sv
// March C- memory BIST engine driving a synchronous single-port RAM, one pass per background.
// Define BIST_DIAG_EN to add first-miscompare diagnostics and a saturating error counter.
module march_bist #(
  parameter int unsigned ADR_SIZE  = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_BG    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADR_SIZE-1:0]  mem_adr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 status
`ifdef BIST_DIAG_EN
  ,
  output logic [ADR_SIZE-1:0]                                fail_adr,
  output logic [2:0]                                         fail_elem,
  output logic [((NUM_BG > 1) ? $clog2(NUM_BG) : 1)-1:0]     fail_bg,
  output logic [DATA_SIZE-1:0]                               fail_xor,
  output logic [7:0]                                         err_cnt
`endif
);

  localparam int unsigned BgW = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
  localparam logic [BgW-1:0]      BgLast = BgW'(NUM_BG - 1);
  localparam logic [BgW-1:0]      BgOne  = BgW'(1);
  localparam logic [ADR_SIZE-1:0] AdrMax = '1;
  localparam logic [ADR_SIZE-1:0] AdrOne = ADR_SIZE'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADR_SIZE-1:0] adr_q, adr_d;
  logic                ph_q, ph_d;
  logic [BgW-1:0]      bg_q, bg_d;

  logic                 pend_q, err_q;
  logic [DATA_SIZE-1:0] exp_q;

  logic                 is_read, inv, last_ph, down, last_adr, accept, miscmp, run;
  logic [DATA_SIZE-1:0] bg_pat, op_data;

  // Background k>=1: bit i of the word is bit (k-1) of i.
  function automatic logic [DATA_SIZE-1:0] bg_pattern(input logic [BgW-1:0] k);
    logic [DATA_SIZE-1:0] pat;
    pat = '0;
    for (int i = 0; i < int'(DATA_SIZE); i++) begin
      if (k != '0) pat[i] = ((i >> (int'(k) - 1)) & 1) != 0;
    end
    return pat;
  endfunction

  // Op decode: ph_q selects the read or write half of a two-op element.
  always_comb begin
    is_read = 1'b0;
    inv     = 1'b0;
    last_ph = 1'b1;
    case (elem_q)
      3'd1, 3'd3: begin
        is_read = ~ph_q;
        inv     = ph_q;
        last_ph = ph_q;
      end
      3'd2, 3'd4: begin
        is_read = ~ph_q;
        inv     = ~ph_q;
        last_ph = ph_q;
      end
      3'd5:    is_read = 1'b1;
      default: ;
    endcase
  end

  assign bg_pat   = bg_pattern(bg_q);
  assign op_data  = inv ? ~bg_pat : bg_pat;
  assign down     = elem_q >= 3'd3;
  assign last_adr = down ? (adr_q == '0) : (adr_q == AdrMax);
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign miscmp   = pend_q && (mem_rdata != exp_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      elem_q  <= '0;
      adr_q   <= '0;
      ph_q    <= 1'b0;
      bg_q    <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      adr_q   <= adr_d;
      ph_q    <= ph_d;
      bg_q    <= bg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    adr_d   = adr_q;
    ph_d    = ph_q;
    bg_d    = bg_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          elem_d  = '0;
          adr_d   = '0;
          ph_d    = 1'b0;
          bg_d    = '0;
        end
      end
      StRun: begin
        if (!last_ph) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!last_adr) begin
            adr_d = down ? adr_q - AdrOne : adr_q + AdrOne;
          end else if (elem_q == 3'd5) begin
            elem_d = '0;
            adr_d  = '0;
            if (bg_q == BgLast) state_d = StDrain;
            else                bg_d    = bg_q + BgOne;
          end else begin
            elem_d = elem_q + 3'd1;
            // Elements 3..5 walk downwards from the top address.
            adr_d  = (elem_q >= 3'd2) ? AdrMax : '0;
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run       = state_q == StRun;
    mem_we    = run & ~is_read;
    mem_re    = run & is_read;
    mem_adr   = run ? adr_q : '0;
    mem_wdata = mem_we ? op_data : '0;
    busy      = run | (state_q == StDrain);
    done      = state_q == StDone;
    status    = done & ~err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      exp_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= mem_re;
      exp_q  <= op_data;
      if (accept)      err_q <= 1'b0;
      else if (miscmp) err_q <= 1'b1;
    end
  end

`ifdef BIST_DIAG_EN
  logic [ADR_SIZE-1:0] cmp_adr_q;
  logic [2:0]          cmp_elem_q;
  logic [BgW-1:0]      cmp_bg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_adr_q  <= '0;
      cmp_elem_q <= '0;
      cmp_bg_q   <= '0;
      fail_adr   <= '0;
      fail_elem  <= '0;
      fail_bg    <= '0;
      fail_xor   <= '0;
      err_cnt    <= '0;
    end else begin
      cmp_adr_q  <= adr_q;
      cmp_elem_q <= elem_q;
      cmp_bg_q   <= bg_q;
      if (accept) begin
        fail_adr  <= '0;
        fail_elem <= '0;
        fail_bg   <= '0;
        fail_xor  <= '0;
        err_cnt   <= '0;
      end else if (miscmp) begin
        if (!err_q) begin
          fail_adr  <= cmp_adr_q;
          fail_elem <= cmp_elem_q;
          fail_bg   <= cmp_bg_q;
          fail_xor  <= mem_rdata ^ exp_q;
        end
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_march_bist.sv
// Bench for march_bist: 1- and 4-background instances on fault-injectable RAMs, checked
// against a March C- reference op list and a first-failure model built from returned data.
module tb_march_bist;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst, start_a, start_b, mem_clr, sel;
  always #5 clk = ~clk;

  int n_checks, n_fail;
  int fkind, fadr, fbit, fvic;

  logic [AW-1:0] a_adr, b_adr, s_adr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, s_wdata, s_rdata;
  logic a_we, a_re, a_busy, a_done, a_status;
  logic b_we, b_re, b_busy, b_done, b_status;
  logic s_we, s_re, s_busy, s_done, s_status;
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
`ifdef BIST_DIAG_EN
  logic [AW-1:0] a_fadr, b_fadr, s_fadr;
  logic [2:0]    a_felem, b_felem, s_felem;
  logic [0:0]    a_fbg;
  logic [1:0]    b_fbg, s_fbg;
  logic [DW-1:0] a_fxor, b_fxor, s_fxor;
  logic [7:0]    a_ecnt, b_ecnt, s_ecnt;
`endif

  march_bist #(.ADR_SIZE(AW), .DATA_SIZE(DW), .NUM_BG(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_adr(a_adr), .mem_wdata(a_wdata),
    .mem_we(a_we), .mem_re(a_re), .mem_rdata(a_rdata), .busy(a_busy), .done(a_done),
    .status(a_status)
`ifdef BIST_DIAG_EN
    , .fail_adr(a_fadr), .fail_elem(a_felem), .fail_bg(a_fbg), .fail_xor(a_fxor),
    .err_cnt(a_ecnt)
`endif
  );

  march_bist #(.ADR_SIZE(AW), .DATA_SIZE(DW), .NUM_BG(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_adr(b_adr), .mem_wdata(b_wdata),
    .mem_we(b_we), .mem_re(b_re), .mem_rdata(b_rdata), .busy(b_busy), .done(b_done),
    .status(b_status)
`ifdef BIST_DIAG_EN
    , .fail_adr(b_fadr), .fail_elem(b_felem), .fail_bg(b_fbg), .fail_xor(b_fxor),
    .err_cnt(b_ecnt)
`endif
  );

  // Fault kinds: 0 none, 1 stuck-at-1, 2 stuck-at-0 (fadr/fbit), 3 coupling: a write that
  // changes word fadr flips bit fbit of word fvic.
  function automatic logic [DW-1:0] fault_rd(input int adr, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (adr == fadr && fkind == 1) r[fbit] = 1'b1;
    if (adr == fadr && fkind == 2) r[fbit] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem_a[i] <= '0;
    end else begin
      if (a_we) begin
        mem_a[a_adr] <= a_wdata;
        if (fkind == 3 && int'(a_adr) == fadr && a_wdata != mem_a[a_adr])
          mem_a[fvic][fbit] <= ~mem_a[fvic][fbit];
      end
      if (a_re) a_rdata <= fault_rd(int'(a_adr), mem_a[a_adr]);
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem_b[i] <= '0;
    end else begin
      if (b_we) begin
        mem_b[b_adr] <= b_wdata;
        if (fkind == 3 && int'(b_adr) == fadr && b_wdata != mem_b[b_adr])
          mem_b[fvic][fbit] <= ~mem_b[fvic][fbit];
      end
      if (b_re) b_rdata <= fault_rd(int'(b_adr), mem_b[b_adr]);
    end
  end

  always_comb begin
    s_adr    = sel ? b_adr    : a_adr;
    s_wdata  = sel ? b_wdata  : a_wdata;
    s_rdata  = sel ? b_rdata  : a_rdata;
    s_we     = sel ? b_we     : a_we;
    s_re     = sel ? b_re     : a_re;
    s_busy   = sel ? b_busy   : a_busy;
    s_done   = sel ? b_done   : a_done;
    s_status = sel ? b_status : a_status;
`ifdef BIST_DIAG_EN
    s_fadr   = sel ? b_fadr   : a_fadr;
    s_felem  = sel ? b_felem  : a_felem;
    s_fbg    = sel ? b_fbg    : {1'b0, a_fbg};
    s_fxor   = sel ? b_fxor   : a_fxor;
    s_ecnt   = sel ? b_ecnt   : a_ecnt;
`endif
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference op list: one entry per memory operation in issue order.
  logic          q_we[$];
  int            q_adr[$];
  logic [DW-1:0] q_data[$];
  int            q_elem[$];
  int            q_bg[$];

  function automatic logic [DW-1:0] bg_word(input int k);
    case (k)
      0:       return 8'h00;
      1:       return 8'hAA;
      2:       return 8'hCC;
      default: return 8'hF0;
    endcase
  endfunction

  // Codes: 0 w0, 1 w1, 2 r0, 3 r1, -1 no op.
  function automatic int elem_op(input int e, input int j);
    case (e)
      0:       return (j == 0) ? 0 : -1;
      1, 3:    return (j == 0) ? 2 : 1;
      2, 4:    return (j == 0) ? 3 : 0;
      default: return (j == 0) ? 2 : -1;
    endcase
  endfunction

  task automatic build(input int nbg);
    q_we.delete(); q_adr.delete(); q_data.delete(); q_elem.delete(); q_bg.delete();
    for (int k = 0; k < nbg; k++)
      for (int e = 0; e < 6; e++)
        for (int s = 0; s < N; s++) begin
          int a;
          a = (e >= 3) ? N - 1 - s : s;
          for (int j = 0; j < 2; j++) begin
            int c;
            c = elem_op(e, j);
            if (c >= 0) begin
              q_we.push_back(c < 2);
              q_adr.push_back(a);
              q_data.push_back((c % 2 == 1) ? ~bg_word(k) : bg_word(k));
              q_elem.push_back(e);
              q_bg.push_back(k);
            end
          end
        end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {a_busy, a_done, a_status, a_we, a_re, a_adr, a_wdata}, 64'd0);
    check({tag, "_b"}, {b_busy, b_done, b_status, b_we, b_re, b_adr, b_wdata}, 64'd0);
`ifdef BIST_DIAG_EN
    check({tag, "_diag"}, {a_fadr, a_felem, a_fbg, a_fxor, a_ecnt,
                           b_fadr, b_felem, b_fbg, b_fxor, b_ecnt}, 64'd0);
`endif
  endtask

  // Entered and left 1 time unit after a rising edge; start is sampled on the next edge.
  task automatic run(input logic dsel, input int kind, input int fa, input int fb, input int fv,
                     input int rst_at, input int poke_at);
    int t, prev_i, m_cnt, m_adr, m_elem, m_bg;
    logic prev_rd, m_err, trace_ok;
    logic [DW-1:0] prev_exp, m_xor;
    logic [AW+DW+3:0] exp_v, act_v;
    sel = dsel; fkind = kind; fadr = fa; fbit = fb; fvic = fv;
    build(dsel ? 4 : 1);
    t = q_we.size();
    mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
    if (dsel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    prev_rd = 1'b0; prev_exp = '0; prev_i = 0; trace_ok = 1'b1;
    m_err = 1'b0; m_cnt = 0; m_adr = 0; m_elem = 0; m_bg = 0; m_xor = '0;
    for (int k = 0; k <= t; k++) begin
      if (k == rst_at) begin
        rst = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk); #1 rst = 1'b1;
        return;
      end
      if (prev_rd && s_rdata !== prev_exp) begin
        if (!m_err) begin
          m_adr = q_adr[prev_i]; m_elem = q_elem[prev_i]; m_bg = q_bg[prev_i];
          m_xor = s_rdata ^ prev_exp;
        end
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (k < t) begin
        exp_v = '0;
        exp_v[AW+DW+3]    = 1'b1;
        exp_v[AW+DW+1]    = q_we[k];
        exp_v[AW+DW]      = !q_we[k];
        exp_v[AW+DW-1:DW] = AW'(q_adr[k]);
        if (q_we[k]) exp_v[DW-1:0] = q_data[k];
        act_v = {s_busy, s_done, s_we, s_re, s_adr, s_wdata};
        if (!s_we) act_v[DW-1:0] = '0;
        if (trace_ok) begin
          check("op", 64'(act_v), 64'(exp_v));
          trace_ok = (act_v === exp_v);
        end
        prev_rd = !q_we[k]; prev_exp = q_data[k]; prev_i = k;
        if (k == poke_at) begin
          if (dsel) start_b = 1'b1; else start_a = 1'b1;
        end
      end else begin
        check("drain", {s_busy, s_done, s_we, s_re}, 64'b1000);
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    check("done", {s_busy, s_done, s_status}, {61'd0, 2'b01, !m_err});
`ifdef BIST_DIAG_EN
    check("fail_adr", s_fadr, m_adr);
    check("fail_elem", s_felem, m_elem);
    check("fail_bg", s_fbg, m_bg);
    check("fail_xor", s_fxor, m_xor);
    check("err_cnt", s_ecnt, m_cnt);
`endif
    @(posedge clk); #1;
    check("done_hold", {s_busy, s_done, s_status}, {61'd0, 2'b01, !m_err});
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mem_clr = 1'b0; sel = 1'b0;
    fkind = 0; fadr = 0; fbit = 0; fvic = 0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run(1'b0, 0, 0, 0, 0, -1, 40);      // stray start mid-run must be ignored
    run(1'b0, 1, 5, 3, 0, -1, -1);      // stuck-at-1 bit 3 at adr 5, started from DONE
    check("sa1_status", s_status, 0);
`ifdef BIST_DIAG_EN
    check("sa1_adr", s_fadr, 5);
    check("sa1_elem", s_felem, 1);
    check("sa1_bg", s_fbg, 0);
    check("sa1_xor", s_fxor, 8'h08);
`endif
    run(1'b1, 0, 0, 0, 0, -1, -1);      // four backgrounds, fault-free
    run(1'b0, 3, 9, 0, 8, -1, -1);      // write to 9 flips bit 0 of 8
    check("cf_status", s_status, 0);
`ifdef BIST_DIAG_EN
    check("cf_adr", s_fadr, 8);
    check("cf_elem", s_felem, 2);
`endif
    run(1'b0, 0, 0, 0, 0, 49, -1);      // reset during cycle 50 of a run
    run(1'b0, 0, 0, 0, 0, -1, -1);
    check("after_rst_status", s_status, 1);

    for (int r = 0; r < 8; r++) begin
      int fa, fv;
      fa = $urandom_range(0, N - 1);
      fv = (fa + 1 + $urandom_range(0, N - 2)) % N;
      run(1'($urandom_range(0, 1)), $urandom_range(0, 3), fa, $urandom_range(0, DW - 1), fv,
          -1, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 100) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
